exc_unit: RTL and testbench
===========================

Name: exc_unit

Overview:
Trap sequencer that drives the CSR block's exception write port (we_exc, mcause/mepc/mtval/mstatus data) and redirects fetch on trap entry and MRET.
- Sits between the execute/memory stages and the CSR file.
- Prioritises synchronous exceptions, builds the trap CSR values and sequences commit, pipeline flush and PC redirect through a small FSM.

Parameters:
- FLUSH_CYCLES, 1, cycles flush_o is held between CSR commit and PC redirect (1..15).
- MPP_MODE, 2'b11, privilege value written to mstatus.MPP on trap entry and MRET (M-only core).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-low (0 = reset)
- exc_valid_i  in  1  pipeline presents a valid retiring instruction this cycle
- exc_vec_i  in  16  exception flags, bit n = cause n (RISC-V numbering); only bits 0-7 and 11 are used
- mret_i  in  1  valid instruction is MRET
- exc_pc_i  in  32  PC of the instruction
- exc_instr_i  in  32  instruction bits
- exc_addr_i  in  32  load/store effective address
- mtvec_i  in  32  current mtvec
- mstatus_i  in  32  current mstatus
- mepc_i, mcause_i, mtval_i  in  32 each  current CSR values, passed through on MRET
- irq_i  in  3  {external, timer, software} interrupt requests
- mie_i  in  32  current mie
- irq_pc_i  in  32  PC of the next instruction to execute, used for interrupt mepc
- we_exc_o  out  1  CSR exception write strobe
- mcause_o, mepc_o, mtval_o, mstatus_o  out  32 each  CSR write data
- flush_o  out  1  kill younger pipeline instructions
- stall_o  out  1  freeze the pipeline; high whenever the FSM is not in IDLE
- pc_redirect_o  out  1  load pc_target_o into fetch
- pc_target_o  out  32  redirect target

Behaviour:
- Reset (rst_i=0 at a clock edge): FSM goes to IDLE; every output is 0; any captured event is discarded. This also applies when reset occurs mid-sequence, so no later we_exc_o or redirect is produced.
- FSM states: IDLE -> COMMIT -> FLUSH -> REDIRECT -> IDLE.
- IDLE:
  - If exc_valid_i and any used exc_vec_i bit is set, capture a trap and go to COMMIT.
  - Else if exc_valid_i and mret_i, capture an MRET and go to COMMIT.
  - Other inputs are ignored in every non-IDLE state.
- Exception priority (highest first): 1, 2, 0, 11, 3, 6, 4, 7, 5. An exception beats an MRET in the same cycle.
- mtval by cause:
  - causes 0, 1: exc_pc_i
  - cause 2: exc_instr_i
  - causes 4-7: exc_addr_i
  - causes 3, 11: 0
- Trap entry values:
  - mepc = {exc_pc_i[31:1], 0}
  - mcause = cause
  - mstatus: MPIE[7] <= MIE[3]; MIE <= 0; MPP[12:11] <= MPP_MODE; all other bits unchanged
  - target = {mtvec_i[31:2], 2'b00}
- MRET values:
  - mepc_o, mcause_o, mtval_o = mepc_i, mcause_i, mtval_i (unchanged)
  - mstatus: MIE <= MPIE; MPIE <= 1; MPP <= MPP_MODE
  - target = mepc_i
- COMMIT: one cycle. we_exc_o=1 with all four data outputs valid; flush_o=1. Data outputs are registered and hold until the next capture.
- FLUSH: flush_o=1 for FLUSH_CYCLES cycles, counted by a 4-bit down-counter.
- REDIRECT: one cycle. pc_redirect_o=1 and pc_target_o valid; flush_o=0.
- Latency: event in cycle N -> we_exc_o in N+1 -> redirect in N+2+FLUSH_CYCLES -> IDLE in N+3+FLUSH_CYCLES.
- stall_o=1 in COMMIT, FLUSH and REDIRECT.
- we_exc_o is never high outside COMMIT.

Optional Feature:
IRQ_EN
- With the macro defined, interrupts are taken in IDLE when:
  - no exception is pending, and
  - mstatus_i[3]=1, and
  - some irq_i bit is set whose mie_i enable (bits 11/7/3) is also set.
- Interrupt priority: external (11) > software (3) > timer (7). An interrupt beats an MRET in the same cycle.
- Interrupt trap values: mcause = 0x80000000 | code; mepc = irq_pc_i; mtval = 0.
- Interrupt target: if mtvec_i[1:0]=01, target = base + 4*code; otherwise target = base.
- Without the macro, irq_i, mie_i and irq_pc_i are ignored. Vectored mode is not applied, so exceptions always use base.

Test Plan:
1. Illegal instruction: exc_pc 0x100, instr 0xFFFFFFFF, mtvec 0x200, mstatus 0x8, FLUSH_CYCLES=1 -> N+1: we_exc=1, mcause=2, mepc=0x100, mtval=0xFFFFFFFF, mstatus_o=0x1880. N+2: flush=1. N+3: redirect=1, target 0x200.
2. MRET with mstatus 0x1880, mepc_i 0x104 -> mstatus_o=0x1888, mepc_o=0x104, redirect to 0x104 at N+3.
3. exc_vec bits 4 and 2 set together with mret_i, exc_addr 0x1001 -> mcause=2, mtval=instr, no MRET effects.
4. Store fault with exc_addr 0x80000003 and FLUSH_CYCLES=3 -> mcause=7, mtval=0x80000003, flush high for N+1..N+4, redirect at N+5. New events during N+1..N+5 are ignored.
5. rst_i=0 during FLUSH -> all outputs 0 on the next edge, no redirect ever. A fresh exception afterwards follows the normal timing.
6. IRQ_EN: irq_i=010, mie_i bit 7 set, mstatus 0x8, mtvec 0x201, irq_pc 0x300 -> mcause=0x80000007, mepc=0x300, target 0x21C. Without the macro -> no response.

Source files
------------

// File: rtl/exc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | exc_unit : trap sequencer (exception/MRET -> CSR commit, flush, redirect)   |
// | Optional IRQ_EN: interrupt entry with vectored mtvec. Rev 1.0               |
// +-----------------------------------------------------------------------------+
module exc_unit #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [1:0]  MPP_MODE     = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [15:0] exc_vec_i,
  input  logic        mret_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_instr_i,
  input  logic [31:0] exc_addr_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mtval_i,
  input  logic [2:0]  irq_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] irq_pc_i,
  output logic        we_exc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic [31:0] mstatus_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_COMMIT   = 2'd1;
  localparam logic [1:0]  ST_FLUSH    = 2'd2;
  localparam logic [1:0]  ST_REDIRECT = 2'd3;
  localparam logic [15:0] USED_CAUSES = 16'h08FF;
  localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  flush_cnt;
  logic [31:0] mcause_q, mepc_q, mtval_q, mstatus_q, target_q;

  logic [15:0] exc_used;
  logic        exc_take, mret_take, cap_take;
  logic [3:0]  exc_cause;
  logic [31:0] exc_mtval, trap_mstatus, mret_mstatus, mtvec_base;
  logic        irq_take;
  logic [31:0] irq_cause, irq_target, irq_mepc;
  logic [31:0] cap_mcause, cap_mepc, cap_mtval, cap_mstatus, cap_target;

  assign exc_used   = exc_vec_i & USED_CAUSES;
  assign exc_take   = exc_valid_i && (|exc_used);
  assign mret_take  = exc_valid_i && mret_i;
  assign mtvec_base = {mtvec_i[31:2], 2'b00};

  // Fixed synchronous-exception priority: 1, 2, 0, 11, 3, 6, 4, 7, 5.
  always_comb begin
    exc_cause = 4'd0;
    if      (exc_used[1])  exc_cause = 4'd1;
    else if (exc_used[2])  exc_cause = 4'd2;
    else if (exc_used[0])  exc_cause = 4'd0;
    else if (exc_used[11]) exc_cause = 4'd11;
    else if (exc_used[3])  exc_cause = 4'd3;
    else if (exc_used[6])  exc_cause = 4'd6;
    else if (exc_used[4])  exc_cause = 4'd4;
    else if (exc_used[7])  exc_cause = 4'd7;
    else if (exc_used[5])  exc_cause = 4'd5;
  end

  always_comb begin
    case (exc_cause)
      4'd0, 4'd1:             exc_mtval = exc_pc_i;
      4'd2:                   exc_mtval = exc_instr_i;
      4'd4, 4'd5, 4'd6, 4'd7: exc_mtval = exc_addr_i;
      default:                exc_mtval = 32'd0;
    endcase
  end

  always_comb begin
    trap_mstatus        = mstatus_i;
    trap_mstatus[7]     = mstatus_i[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = MPP_MODE;
    mret_mstatus        = mstatus_i;
    mret_mstatus[3]     = mstatus_i[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = MPP_MODE;
  end

`ifdef IRQ_EN
  logic [2:0] irq_pend;
  logic [3:0] irq_code;

  assign irq_pend = irq_i & {mie_i[11], mie_i[7], mie_i[3]};
  assign irq_take = !exc_take && mstatus_i[3] && (|irq_pend);

  // External beats software beats timer.
  always_comb begin
    irq_code = 4'd7;
    if      (irq_pend[2]) irq_code = 4'd11;
    else if (irq_pend[0]) irq_code = 4'd3;
  end

  assign irq_cause  = {1'b1, 27'd0, irq_code};
  assign irq_mepc   = irq_pc_i;
  assign irq_target = (mtvec_i[1:0] == 2'b01) ? (mtvec_base + {26'd0, irq_code, 2'b00})
                                              : mtvec_base;
`else
  logic unused_irq;

  assign irq_take   = 1'b0;
  assign irq_cause  = 32'd0;
  assign irq_mepc   = 32'd0;
  assign irq_target = 32'd0;
  assign unused_irq = ^{irq_i, mie_i, irq_pc_i, mtvec_i[1:0]};
`endif

  always_comb begin
    cap_take    = exc_take || irq_take || mret_take;
    cap_mcause  = {28'd0, exc_cause};
    cap_mepc    = {exc_pc_i[31:1], 1'b0};
    cap_mtval   = exc_mtval;
    cap_mstatus = trap_mstatus;
    cap_target  = mtvec_base;
    if (!exc_take && irq_take) begin
      cap_mcause = irq_cause;
      cap_mepc   = irq_mepc;
      cap_mtval  = 32'd0;
      cap_target = irq_target;
    end else if (!exc_take && mret_take) begin
      cap_mcause  = mcause_i;
      cap_mepc    = mepc_i;
      cap_mtval   = mtval_i;
      cap_mstatus = mret_mstatus;
      cap_target  = mepc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      flush_cnt <= 4'd0;
      mcause_q  <= 32'd0;
      mepc_q    <= 32'd0;
      mtval_q   <= 32'd0;
      mstatus_q <= 32'd0;
      target_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cap_take) begin
            mcause_q  <= cap_mcause;
            mepc_q    <= cap_mepc;
            mtval_q   <= cap_mtval;
            mstatus_q <= cap_mstatus;
            target_q  <= cap_target;
            state     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          flush_cnt <= FLUSH_LOAD;
          state     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_cnt == 4'd0) state <= ST_REDIRECT;
          else                   flush_cnt <= flush_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign we_exc_o      = (state == ST_COMMIT);
  assign flush_o       = (state == ST_COMMIT) || (state == ST_FLUSH);
  assign stall_o       = (state != ST_IDLE);
  assign pc_redirect_o = (state == ST_REDIRECT);
  assign pc_target_o   = target_q;
  assign mcause_o      = mcause_q;
  assign mepc_o        = mepc_q;
  assign mtval_o       = mtval_q;
  assign mstatus_o     = mstatus_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_unit.sv
`default_nettype none
// Bench for exc_unit: two instances (FLUSH_CYCLES 1 and 3) share stimulus and
// are compared cycle by cycle against a rule-level trap model.
module tb_exc_unit;

  typedef struct {
    logic        valid;
    logic [15:0] vec;
    logic        mret;
    logic [31:0] pc, instr, addr, mtvec, mstatus, mepc, mcause, mtval;
    logic [2:0]  irq;
    logic [31:0] mie, irq_pc;
  } stim_t;

  typedef struct {
    logic        take;
    logic [31:0] mcause, mepc, mtval, mstatus, target;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int PRIO [9] = '{1, 2, 0, 11, 3, 6, 4, 7, 5};

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_a, valid_b, mret;
  logic [2:0]  irq_a, irq_b;
  logic [15:0] exc_vec;
  logic [31:0] exc_pc, exc_instr, exc_addr, mtvec, mstatus, mepc_in, mcause_in, mtval_in, mie, irq_pc;

  logic        we_a, flush_a, stall_a, redir_a;
  logic [31:0] mcause_a, mepc_a, mtval_a, mstatus_a, target_a;
  logic        we_b, flush_b, stall_b, redir_b;
  logic [31:0] mcause_b, mepc_b, mtval_b, mstatus_b, target_b;

  int total = 0;
  int bad   = 0;
  vec_t tbl [13];

  always #5 clk = ~clk;

  exc_unit #(.FLUSH_CYCLES(1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .exc_valid_i(valid_a), .exc_vec_i(exc_vec), .mret_i(mret),
    .exc_pc_i(exc_pc), .exc_instr_i(exc_instr), .exc_addr_i(exc_addr), .mtvec_i(mtvec),
    .mstatus_i(mstatus), .mepc_i(mepc_in), .mcause_i(mcause_in), .mtval_i(mtval_in),
    .irq_i(irq_a), .mie_i(mie), .irq_pc_i(irq_pc),
    .we_exc_o(we_a), .mcause_o(mcause_a), .mepc_o(mepc_a), .mtval_o(mtval_a),
    .mstatus_o(mstatus_a), .flush_o(flush_a), .stall_o(stall_a),
    .pc_redirect_o(redir_a), .pc_target_o(target_a)
  );

  exc_unit #(.FLUSH_CYCLES(3)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .exc_valid_i(valid_b), .exc_vec_i(exc_vec), .mret_i(mret),
    .exc_pc_i(exc_pc), .exc_instr_i(exc_instr), .exc_addr_i(exc_addr), .mtvec_i(mtvec),
    .mstatus_i(mstatus), .mepc_i(mepc_in), .mcause_i(mcause_in), .mtval_i(mtval_in),
    .irq_i(irq_b), .mie_i(mie), .irq_pc_i(irq_pc),
    .we_exc_o(we_b), .mcause_o(mcause_b), .mepc_o(mepc_b), .mtval_o(mtval_b),
    .mstatus_o(mstatus_b), .flush_o(flush_b), .stall_o(stall_b),
    .pc_redirect_o(redir_b), .pc_target_o(target_b)
  );

  function automatic logic [31:0] enter_ms(input logic [31:0] ms);
    return (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    int   cause;
    e = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    cause = -1;
    if (s.valid)
      for (int i = 0; i < 9; i++)
        if (cause < 0 && s.vec[PRIO[i]]) cause = PRIO[i];
    if (cause >= 0) begin
      e.take    = 1'b1;
      e.mcause  = 32'(cause);
      e.mepc    = s.pc & ~32'h1;
      if (cause <= 1)                    e.mtval = s.pc;
      else if (cause == 2)               e.mtval = s.instr;
      else if (cause >= 4 && cause <= 7) e.mtval = s.addr;
      else                               e.mtval = 32'd0;
      e.mstatus = enter_ms(s.mstatus);
      e.target  = s.mtvec & ~32'h3;
      return e;
    end
`ifdef IRQ_EN
    begin
      logic [2:0] pend;
      int code;
      pend = s.irq & {s.mie[11], s.mie[7], s.mie[3]};
      if (s.mstatus[3] && pend != 3'b000) begin
        code      = pend[2] ? 11 : (pend[0] ? 3 : 7);
        e.take    = 1'b1;
        e.mcause  = 32'h8000_0000 | 32'(code);
        e.mepc    = s.irq_pc;
        e.mtval   = 32'd0;
        e.mstatus = enter_ms(s.mstatus);
        e.target  = (s.mtvec & ~32'h3) + ((s.mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'd0);
        return e;
      end
    end
`endif
    if (s.valid && s.mret) begin
      e.take    = 1'b1;
      e.mcause  = s.mcause;
      e.mepc    = s.mepc;
      e.mtval   = s.mtval;
      e.mstatus = (s.mstatus & ~32'h1888) | (s.mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
      e.target  = s.mepc;
    end
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 2))
      0:       s.vec = 16'd0;
      1:       s.vec = 16'(1 << $urandom_range(0, 15));
      default: s.vec = 16'($urandom) & 16'($urandom);
    endcase
    s.mret    = 1'($urandom);
    s.pc      = $urandom;
    s.instr   = $urandom;
    s.addr    = $urandom;
    s.mtvec   = $urandom;
    s.mstatus = $urandom;
    s.mepc    = $urandom;
    s.mcause  = $urandom;
    s.mtval   = $urandom;
    s.irq     = 3'($urandom);
    s.mie     = $urandom;
    s.irq_pc  = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic apply(input stim_t s);
    valid_a = s.valid;   valid_b = s.valid;
    irq_a   = s.irq;     irq_b   = s.irq;
    exc_vec = s.vec;     mret    = s.mret;
    exc_pc  = s.pc;      exc_instr = s.instr;  exc_addr = s.addr;
    mtvec   = s.mtvec;   mstatus = s.mstatus;
    mepc_in = s.mepc;    mcause_in = s.mcause; mtval_in = s.mtval;
    mie     = s.mie;     irq_pc  = s.irq_pc;
  endtask

  task automatic drive_quiet();
    valid_a = 1'b0; valid_b = 1'b0; irq_a = 3'b000; irq_b = 3'b000;
    mret = 1'b0; exc_vec = 16'd0;
  endtask

  // Random traffic aimed at each instance only while it is busy.
  task automatic drive_busy(input int k);
    apply(rand_stim());
    valid_a = (k <= 3) ? 1'($urandom) : 1'b0;
    valid_b = (k <= 5) ? 1'($urandom) : 1'b0;
    irq_a   = (k <= 3) ? 3'($urandom) : 3'b000;
    irq_b   = (k <= 5) ? 3'($urandom) : 3'b000;
  endtask

  task automatic check_inst(input string tag, input int f, input int k, input exp_t e,
                            input logic we, input logic fl, input logic st, input logic rd,
                            input logic [31:0] mc, input logic [31:0] mp, input logic [31:0] mt,
                            input logic [31:0] ms, input logic [31:0] tg);
    chk($sformatf("%s k%0d we_exc", tag, k),   {31'd0, we}, {31'd0, k == 1});
    chk($sformatf("%s k%0d flush", tag, k),    {31'd0, fl}, {31'd0, k <= 1 + f});
    chk($sformatf("%s k%0d stall", tag, k),    {31'd0, st}, {31'd0, k <= 2 + f});
    chk($sformatf("%s k%0d redirect", tag, k), {31'd0, rd}, {31'd0, k == 2 + f});
    if (k == 1 || k == 2 + f) begin
      chk($sformatf("%s k%0d mcause", tag, k),  mc, e.mcause);
      chk($sformatf("%s k%0d mepc", tag, k),    mp, e.mepc);
      chk($sformatf("%s k%0d mtval", tag, k),   mt, e.mtval);
      chk($sformatf("%s k%0d mstatus", tag, k), ms, e.mstatus);
    end
    if (k == 2 + f) chk($sformatf("%s k%0d target", tag, k), tg, e.target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a_ctl"}, {28'd0, we_a, flush_a, stall_a, redir_a}, 32'd0);
    chk({tag, " b_ctl"}, {28'd0, we_b, flush_b, stall_b, redir_b}, 32'd0);
    chk({tag, " a_data"}, mcause_a | mepc_a | mtval_a | mstatus_a | target_a, 32'd0);
    chk({tag, " b_data"}, mcause_b | mepc_b | mtval_b | mstatus_b | target_b, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    apply(v.s);
    step();
    if (v.e.take) begin
      for (int k = 1; k <= 6; k++) begin
        check_inst({name, "/a"}, 1, k, v.e, we_a, flush_a, stall_a, redir_a,
                   mcause_a, mepc_a, mtval_a, mstatus_a, target_a);
        check_inst({name, "/b"}, 3, k, v.e, we_b, flush_b, stall_b, redir_b,
                   mcause_b, mepc_b, mtval_b, mstatus_b, target_b);
        drive_busy(k);
        step();
      end
      drive_quiet();
    end else begin
      drive_quiet();
      for (int k = 1; k <= 3; k++) begin
        chk($sformatf("%s k%0d idle_a", name, k), {29'd0, we_a, stall_a, redir_a}, 32'd0);
        chk($sformatf("%s k%0d idle_b", name, k), {29'd0, we_b, stall_b, redir_b}, 32'd0);
        step();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0].s  = '{1'b1, 16'h0004, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h200, 32'h8, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[0].e  = '{1'b1, 32'h2, 32'h100, 32'hFFFF_FFFF, 32'h1880, 32'h200};
    tbl[1].s  = '{1'b1, 16'h0000, 1'b1, 32'h200, 32'h3020_0073, 32'h0, 32'h200, 32'h1880, 32'h104, 32'h2, 32'hFFFF_FFFF, 3'b000, 32'h0, 32'h0};
    tbl[1].e  = '{1'b1, 32'h2, 32'h104, 32'hFFFF_FFFF, 32'h1888, 32'h104};
    tbl[2].s  = '{1'b1, 16'h0014, 1'b1, 32'h400, 32'h1234_5678, 32'h1001, 32'h200, 32'h1888, 32'h104, 32'h2, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[2].e  = '{1'b1, 32'h2, 32'h400, 32'h1234_5678, 32'h1880, 32'h200};
    tbl[3].s  = '{1'b1, 16'h0080, 1'b0, 32'h500, 32'h0011_2023, 32'h8000_0003, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[3].e  = '{1'b1, 32'h7, 32'h500, 32'h8000_0003, 32'h1800, 32'h300};
    tbl[4].s  = '{1'b1, 16'h0001, 1'b0, 32'h603, 32'h0, 32'h0, 32'h205, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[4].e  = '{1'b1, 32'h0, 32'h602, 32'h603, 32'hFFFF_FFF7, 32'h204};
    tbl[5].s  = '{1'b1, 16'h0808, 1'b0, 32'h700, 32'h73, 32'h0, 32'h1000, 32'h80, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[5].e  = '{1'b1, 32'd11, 32'h700, 32'h0, 32'h1800, 32'h1000};
    tbl[6].s  = '{1'b1, 16'hF700, 1'b0, 32'h800, 32'h0, 32'h0, 32'h200, 32'h8, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[6].e  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[7].s  = '{1'b0, 16'h0004, 1'b1, 32'h900, 32'h0, 32'h0, 32'h200, 32'h8, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[7].e  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[8].s  = '{1'b0, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h201, 32'h8, 32'h0, 32'h0, 32'h0, 3'b010, 32'h80, 32'h300};
    tbl[9].s  = '{1'b1, 16'h0000, 1'b1, 32'h880, 32'h0, 32'h0, 32'h400, 32'h8, 32'h900, 32'h5, 32'h77, 3'b111, 32'h888, 32'h800};
`ifdef IRQ_EN
    tbl[8].e  = '{1'b1, 32'h8000_0007, 32'h300, 32'h0, 32'h1880, 32'h21C};
    tbl[9].e  = '{1'b1, 32'h8000_000B, 32'h800, 32'h0, 32'h1880, 32'h400};
`else
    tbl[8].e  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[9].e  = '{1'b1, 32'h5, 32'h900, 32'h77, 32'h1880, 32'h900};
`endif
    tbl[10].s = '{1'b0, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001, 32'h8, 32'h340};
    tbl[10].e = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[11].s = '{1'b1, 16'h0008, 1'b0, 32'h40, 32'h0010_0073, 32'h0, 32'h201, 32'h8, 32'h0, 32'h0, 32'h0, 3'b100, 32'h800, 32'h44};
    tbl[11].e = '{1'b1, 32'h3, 32'h40, 32'h0, 32'h1880, 32'h200};
    tbl[12].s = '{1'b1, 16'h0050, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEE1, 32'h100, 32'h1808, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0};
    tbl[12].e = '{1'b1, 32'h6, 32'h20, 32'hDEAD_BEE1, 32'h1880, 32'h100};

    apply(tbl[0].s);
    drive_quiet();
    rst_i = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst_i = 1'b1;
    step();

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Reset while the FLUSH_CYCLES=3 instance is flushing: nothing may follow.
    apply(tbl[3].s);
    step();
    drive_quiet();
    step();
    rst_i = 1'b0;
    step();
    chk_all_zero("midreset");
    rst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("postreset k%0d quiet_a", k), {29'd0, we_a, stall_a, redir_a}, 32'd0);
      chk($sformatf("postreset k%0d quiet_b", k), {29'd0, we_b, stall_b, redir_b}, 32'd0);
    end
    run_vec(tbl[0], "after_reset");

    for (int i = 0; i < 60; i++) begin
      vec_t v;
      v.s = rand_stim();
      v.e = model(v.s);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
